// File: rtl/decode_scoreboard.sv
// decode_scoreboard
// Pending-write scoreboard for the Decode stage. Each scalar register, vector
// register and the condition code has a small counter of writes that have
// issued but not yet retired. The block decides each cycle whether the
// instruction in Decode may issue, and it tracks issues and writebacks.
//
// Ports:
//   I_CLOCK, I_RESET            clock and synchronous active-high reset
//   I_LOCK                      global enable; low freezes state and blocks issue
//   I_FE_Valid                  Decode holds a valid instruction
//   I_GPUStallSignal            downstream stall, blocks issue
//   I_Src*/I_VSrc*/I_CCUse      scalar, vector and CC sources read by the instruction
//   I_Dest*/I_VDest*/I_CCWrite  destinations written by the instruction
//   I_WB*                       writeback retires for scalar, vector and CC
//   O_DepStallSignal            RAW hazard or destination counter full (combinational)
//   O_Issue                     instruction issues this cycle (combinational)
//   O_Pending                   total outstanding writes (registered)
//   O_Underflow                 sticky flag: a retire hit a zero counter
module decode_scoreboard #(
  parameter int NUM_RF    = 16,
  parameter int NUM_VRF   = 64,
  parameter int RF_ID_W   = 4,
  parameter int VRF_ID_W  = 6,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET,
  input  logic                I_LOCK,
  input  logic                I_FE_Valid,
  input  logic                I_GPUStallSignal,
  input  logic [RF_ID_W-1:0]  I_Src1Idx,
  input  logic [RF_ID_W-1:0]  I_Src2Idx,
  input  logic                I_Src1Use,
  input  logic                I_Src2Use,
  input  logic [VRF_ID_W-1:0] I_VSrc1Idx,
  input  logic [VRF_ID_W-1:0] I_VSrc2Idx,
  input  logic                I_VSrc1Use,
  input  logic                I_VSrc2Use,
  input  logic                I_CCUse,
  input  logic [RF_ID_W-1:0]  I_DestIdx,
  input  logic                I_DestWrite,
  input  logic [VRF_ID_W-1:0] I_VDestIdx,
  input  logic                I_VDestWrite,
  input  logic                I_CCWrite,
  input  logic                I_WBRegWEn,
  input  logic [RF_ID_W-1:0]  I_WBRegIdx,
  input  logic                I_WBVRegWEn,
  input  logic [VRF_ID_W-1:0] I_WBVRegIdx,
  input  logic                I_WBCCWEn,
  output logic                O_DepStallSignal,
  output logic                O_Issue,
  output logic [7:0]          O_Pending,
  output logic                O_Underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             BYPASS  = (WB_BYPASS != 0);

  logic [CNT_W-1:0] cnt_rf       [NUM_RF];
  logic [CNT_W-1:0] cnt_vrf      [NUM_VRF];
  logic [CNT_W-1:0] cnt_cc;
  logic [CNT_W-1:0] cnt_rf_next  [NUM_RF];
  logic [CNT_W-1:0] cnt_vrf_next [NUM_VRF];
  logic [CNT_W-1:0] cnt_cc_next;

  logic src1_ok, src2_ok, dest_ok, vsrc1_ok, vsrc2_ok, vdest_ok;
  logic wb_rf_ok, wb_vrf_ok;
  logic any_busy, any_full;
  logic inc_rf, inc_vrf, inc_cc;
  logic dec_rf, dec_vrf, dec_cc;
  logic uf_rf, uf_vrf, uf_cc;

  // A source with exactly one write in flight is released early when that
  // write retires in the same cycle and bypass is enabled.
  function automatic logic src_busy(logic rd, logic in_range,
                                    logic [CNT_W-1:0] cnt, logic wb_hit);
    return rd && in_range && (cnt != '0) && !(BYPASS && (cnt == CNT_ONE) && wb_hit);
  endfunction

  // A destination cannot take another write once its counter is saturated,
  // unless a retire of the same entry frees a slot this cycle.
  function automatic logic dest_full(logic wr, logic in_range,
                                     logic [CNT_W-1:0] cnt, logic wb_hit);
    return wr && in_range && (cnt == CNT_MAX) && !wb_hit;
  endfunction

  // Indices past the tracked register count are never busy and never update.
  assign src1_ok   = int'(I_Src1Idx)   < NUM_RF;
  assign src2_ok   = int'(I_Src2Idx)   < NUM_RF;
  assign dest_ok   = int'(I_DestIdx)   < NUM_RF;
  assign vsrc1_ok  = int'(I_VSrc1Idx)  < NUM_VRF;
  assign vsrc2_ok  = int'(I_VSrc2Idx)  < NUM_VRF;
  assign vdest_ok  = int'(I_VDestIdx)  < NUM_VRF;
  assign wb_rf_ok  = I_WBRegWEn  && (int'(I_WBRegIdx)  < NUM_RF);
  assign wb_vrf_ok = I_WBVRegWEn && (int'(I_WBVRegIdx) < NUM_VRF);

  assign any_busy =
      src_busy(I_Src1Use,  src1_ok,  cnt_rf[I_Src1Idx],   wb_rf_ok  && (I_WBRegIdx  == I_Src1Idx))
    | src_busy(I_Src2Use,  src2_ok,  cnt_rf[I_Src2Idx],   wb_rf_ok  && (I_WBRegIdx  == I_Src2Idx))
    | src_busy(I_VSrc1Use, vsrc1_ok, cnt_vrf[I_VSrc1Idx], wb_vrf_ok && (I_WBVRegIdx == I_VSrc1Idx))
    | src_busy(I_VSrc2Use, vsrc2_ok, cnt_vrf[I_VSrc2Idx], wb_vrf_ok && (I_WBVRegIdx == I_VSrc2Idx))
    | src_busy(I_CCUse,    1'b1,     cnt_cc,              I_WBCCWEn);

  assign any_full =
      dest_full(I_DestWrite,  dest_ok,  cnt_rf[I_DestIdx],   wb_rf_ok  && (I_WBRegIdx  == I_DestIdx))
    | dest_full(I_VDestWrite, vdest_ok, cnt_vrf[I_VDestIdx], wb_vrf_ok && (I_WBVRegIdx == I_VDestIdx))
    | dest_full(I_CCWrite,    1'b1,     cnt_cc,              I_WBCCWEn);

  assign O_DepStallSignal = I_FE_Valid && I_LOCK && (any_busy || any_full);
  assign O_Issue          = I_FE_Valid && I_LOCK && !O_DepStallSignal && !I_GPUStallSignal;

  // Retires against a zero counter are dropped and only raise the error flag.
  assign inc_rf  = O_Issue && I_DestWrite  && dest_ok;
  assign inc_vrf = O_Issue && I_VDestWrite && vdest_ok;
  assign inc_cc  = O_Issue && I_CCWrite;
  assign dec_rf  = wb_rf_ok  && (cnt_rf[I_WBRegIdx]   != '0);
  assign dec_vrf = wb_vrf_ok && (cnt_vrf[I_WBVRegIdx] != '0);
  assign dec_cc  = I_WBCCWEn && (cnt_cc != '0);
  assign uf_rf   = wb_rf_ok  && (cnt_rf[I_WBRegIdx]   == '0);
  assign uf_vrf  = wb_vrf_ok && (cnt_vrf[I_WBVRegIdx] == '0);
  assign uf_cc   = I_WBCCWEn && (cnt_cc == '0);

  // Next-count computation for every entry: add the issued write, subtract
  // the accepted retire. Both on one entry cancel out.
  always_comb begin
    cnt_rf_next  = cnt_rf;
    cnt_vrf_next = cnt_vrf;
    cnt_cc_next  = cnt_cc;
    for (int i = 0; i < NUM_RF; i++) begin
      cnt_rf_next[i] = cnt_rf[i]
                     + CNT_W'(inc_rf && (int'(I_DestIdx)  == i))
                     - CNT_W'(dec_rf && (int'(I_WBRegIdx) == i));
    end
    for (int i = 0; i < NUM_VRF; i++) begin
      cnt_vrf_next[i] = cnt_vrf[i]
                      + CNT_W'(inc_vrf && (int'(I_VDestIdx)  == i))
                      - CNT_W'(dec_vrf && (int'(I_WBVRegIdx) == i));
    end
    cnt_cc_next = cnt_cc + CNT_W'(inc_cc) - CNT_W'(dec_cc);
  end

  // State register. Reset wins over everything; with I_LOCK low the whole
  // scoreboard holds, so retires seen while locked are lost on purpose.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      cnt_rf      <= '{default: '0};
      cnt_vrf     <= '{default: '0};
      cnt_cc      <= '0;
      O_Pending   <= '0;
      O_Underflow <= 1'b0;
    end else if (I_LOCK) begin
      cnt_rf      <= cnt_rf_next;
      cnt_vrf     <= cnt_vrf_next;
      cnt_cc      <= cnt_cc_next;
      O_Pending   <= O_Pending + 8'(inc_rf) + 8'(inc_vrf) + 8'(inc_cc)
                                - 8'(dec_rf) - 8'(dec_vrf) - 8'(dec_cc);
      O_Underflow <= O_Underflow | uf_rf | uf_vrf | uf_cc;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard
// Directed scenarios followed by random traffic, all compared against a
// count-per-register reference model kept in this file.
module tb_decode_scoreboard;

  localparam int NUM_RF    = 16;
  localparam int NUM_VRF   = 64;
  localparam int RF_ID_W   = 4;
  localparam int VRF_ID_W  = 6;
  localparam int CNT_W     = 2;
  localparam int WB_BYPASS = 1;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset, lock, fe_valid, gpu_stall;
  logic [RF_ID_W-1:0]  src1_idx, src2_idx, dest_idx, wb_reg_idx;
  logic [VRF_ID_W-1:0] vsrc1_idx, vsrc2_idx, vdest_idx, wb_vreg_idx;
  logic src1_use, src2_use, vsrc1_use, vsrc2_use, cc_use;
  logic dest_write, vdest_write, cc_write;
  logic wb_reg_wen, wb_vreg_wen, wb_cc_wen;
  logic stall, issue, underflow;
  logic [7:0] pending;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: outstanding writes per register
  int m_rf  [NUM_RF];
  int m_vrf [NUM_VRF];
  int m_cc;
  int m_pend;
  bit m_uf;

  decode_scoreboard #(
    .NUM_RF(NUM_RF), .NUM_VRF(NUM_VRF), .RF_ID_W(RF_ID_W), .VRF_ID_W(VRF_ID_W),
    .CNT_W(CNT_W), .WB_BYPASS(WB_BYPASS)
  ) dut (
    .I_CLOCK(clock), .I_RESET(reset), .I_LOCK(lock), .I_FE_Valid(fe_valid),
    .I_GPUStallSignal(gpu_stall),
    .I_Src1Idx(src1_idx), .I_Src2Idx(src2_idx), .I_Src1Use(src1_use), .I_Src2Use(src2_use),
    .I_VSrc1Idx(vsrc1_idx), .I_VSrc2Idx(vsrc2_idx), .I_VSrc1Use(vsrc1_use), .I_VSrc2Use(vsrc2_use),
    .I_CCUse(cc_use),
    .I_DestIdx(dest_idx), .I_DestWrite(dest_write),
    .I_VDestIdx(vdest_idx), .I_VDestWrite(vdest_write), .I_CCWrite(cc_write),
    .I_WBRegWEn(wb_reg_wen), .I_WBRegIdx(wb_reg_idx),
    .I_WBVRegWEn(wb_vreg_wen), .I_WBVRegIdx(wb_vreg_idx), .I_WBCCWEn(wb_cc_wen),
    .O_DepStallSignal(stall), .O_Issue(issue), .O_Pending(pending), .O_Underflow(underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // A source is busy while writes are outstanding, except a lone write that
  // retires this very cycle when bypass is on.
  function automatic bit srcBusy(int cnt, bit wb_hit);
    return (cnt > 0) && !((WB_BYPASS != 0) && cnt == 1 && wb_hit);
  endfunction

  task automatic modelComb(output bit exp_stall, output bit exp_issue);
    bit busy;
    bit full;
    busy = 0;
    full = 0;
    if (src1_use)  busy |= srcBusy(m_rf[src1_idx],   wb_reg_wen  && wb_reg_idx  == src1_idx);
    if (src2_use)  busy |= srcBusy(m_rf[src2_idx],   wb_reg_wen  && wb_reg_idx  == src2_idx);
    if (vsrc1_use) busy |= srcBusy(m_vrf[vsrc1_idx], wb_vreg_wen && wb_vreg_idx == vsrc1_idx);
    if (vsrc2_use) busy |= srcBusy(m_vrf[vsrc2_idx], wb_vreg_wen && wb_vreg_idx == vsrc2_idx);
    if (cc_use)    busy |= srcBusy(m_cc, wb_cc_wen);
    if (dest_write  && m_rf[dest_idx]   == MAXC && !(wb_reg_wen  && wb_reg_idx  == dest_idx))  full = 1;
    if (vdest_write && m_vrf[vdest_idx] == MAXC && !(wb_vreg_wen && wb_vreg_idx == vdest_idx)) full = 1;
    if (cc_write    && m_cc == MAXC && !wb_cc_wen) full = 1;
    exp_stall = fe_valid && lock && (busy || full);
    exp_issue = fe_valid && lock && !exp_stall && !gpu_stall;
  endtask

  // Retires are judged against the count before this cycle's issue.
  task automatic modelUpdate(input bit did_issue);
    if (reset) begin
      foreach (m_rf[i])  m_rf[i]  = 0;
      foreach (m_vrf[i]) m_vrf[i] = 0;
      m_cc = 0;
      m_uf = 0;
    end else if (lock) begin
      if (wb_reg_wen) begin
        if (m_rf[wb_reg_idx] == 0) m_uf = 1; else m_rf[wb_reg_idx]--;
      end
      if (wb_vreg_wen) begin
        if (m_vrf[wb_vreg_idx] == 0) m_uf = 1; else m_vrf[wb_vreg_idx]--;
      end
      if (wb_cc_wen) begin
        if (m_cc == 0) m_uf = 1; else m_cc--;
      end
      if (did_issue) begin
        if (dest_write)  m_rf[dest_idx]++;
        if (vdest_write) m_vrf[vdest_idx]++;
        if (cc_write)    m_cc++;
      end
    end
    m_pend = m_cc;
    foreach (m_rf[i])  m_pend += m_rf[i];
    foreach (m_vrf[i]) m_pend += m_vrf[i];
  endtask

  task automatic idleInputs();
    reset = 0; lock = 1; fe_valid = 0; gpu_stall = 0;
    src1_idx = '0; src2_idx = '0; dest_idx = '0; wb_reg_idx = '0;
    vsrc1_idx = '0; vsrc2_idx = '0; vdest_idx = '0; wb_vreg_idx = '0;
    src1_use = 0; src2_use = 0; vsrc1_use = 0; vsrc2_use = 0; cc_use = 0;
    dest_write = 0; vdest_write = 0; cc_write = 0;
    wb_reg_wen = 0; wb_vreg_wen = 0; wb_cc_wen = 0;
  endtask

  // Fixed expectations for the combinational outputs of the current inputs
  task automatic expectNow(input string tag, input bit exp_stall, input bit exp_issue);
    #1;
    checkOutput({tag, ":stall"}, 32'(stall), 32'(exp_stall));
    checkOutput({tag, ":issue"}, 32'(issue), 32'(exp_issue));
  endtask

  // One clock cycle: compare combinational outputs before the edge and the
  // registered outputs after it, both against the model.
  task automatic applyStimulus(input string tag);
    bit exp_stall;
    bit exp_issue;
    #1;
    modelComb(exp_stall, exp_issue);
    checkOutput({tag, ":m_stall"}, 32'(stall), 32'(exp_stall));
    checkOutput({tag, ":m_issue"}, 32'(issue), 32'(exp_issue));
    @(posedge clock);
    modelUpdate(exp_issue);
    #1;
    checkOutput({tag, ":pending"},   32'(pending),   32'(m_pend));
    checkOutput({tag, ":underflow"}, 32'(underflow), 32'(m_uf));
  endtask

  initial begin
    idleInputs();
    foreach (m_rf[i])  m_rf[i]  = 0;
    foreach (m_vrf[i]) m_vrf[i] = 0;
    m_cc = 0; m_pend = 0; m_uf = 0;

    // Reset with a source in use must leave nothing stalled
    reset = 1; fe_valid = 1; src1_use = 1;
    repeat (2) @(posedge clock);
    #1;
    expectNow("reset", 0, 1);
    applyStimulus("reset");
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_underflow", 32'(underflow), 32'd0);

    // RAW on R3, released by a same-cycle writeback
    idleInputs();
    fe_valid = 1; dest_write = 1; dest_idx = 4'd3;
    expectNow("raw_issue", 0, 1);
    applyStimulus("raw_issue");
    checkOutput("raw_pending1", 32'(pending), 32'd1);
    dest_write = 0; src1_use = 1; src1_idx = 4'd3;
    expectNow("raw_dep1", 1, 0);
    applyStimulus("raw_dep1");
    applyStimulus("raw_dep2");
    wb_reg_wen = 1; wb_reg_idx = 4'd3;
    expectNow("raw_bypass", 0, 1);
    applyStimulus("raw_bypass");
    checkOutput("raw_pending0", 32'(pending), 32'd0);

    // Branch waiting on CC
    idleInputs();
    fe_valid = 1; cc_write = 1;
    applyStimulus("cc_write");
    checkOutput("cc_pending1", 32'(pending), 32'd1);
    cc_write = 0; cc_use = 1;
    expectNow("cc_branch", 1, 0);
    applyStimulus("cc_branch");
    wb_cc_wen = 1;
    expectNow("cc_release", 0, 1);
    applyStimulus("cc_release");
    checkOutput("cc_pending0", 32'(pending), 32'd0);

    // Saturate V5, then a fourth write only goes with a same-cycle retire
    idleInputs();
    fe_valid = 1; vdest_write = 1; vdest_idx = 6'd5;
    repeat (3) applyStimulus("sat_fill");
    checkOutput("sat_pending3", 32'(pending), 32'd3);
    expectNow("sat_full", 1, 0);
    applyStimulus("sat_full");
    wb_vreg_wen = 1; wb_vreg_idx = 6'd5;
    expectNow("sat_swap", 0, 1);
    applyStimulus("sat_swap");
    checkOutput("sat_pending_hold", 32'(pending), 32'd3);
    wb_vreg_wen = 0;
    expectNow("sat_still_full", 1, 0);
    applyStimulus("sat_still_full");
    fe_valid = 0; vdest_write = 0; wb_vreg_wen = 1;
    repeat (3) applyStimulus("sat_drain");
    checkOutput("sat_pending0", 32'(pending), 32'd0);

    // Issue and retire of R2 together keep its count
    idleInputs();
    fe_valid = 1; dest_write = 1; dest_idx = 4'd2;
    applyStimulus("simul_first");
    wb_reg_wen = 1; wb_reg_idx = 4'd2;
    applyStimulus("simul_both");
    checkOutput("simul_pending", 32'(pending), 32'd1);
    dest_write = 0; wb_reg_wen = 0; src1_use = 1; src1_idx = 4'd2;
    expectNow("simul_dep", 1, 0);
    applyStimulus("simul_dep");
    fe_valid = 0; src1_use = 0; wb_reg_wen = 1;
    applyStimulus("simul_drain");

    // Retire of an idle register is an underflow that sticks
    idleInputs();
    wb_reg_wen = 1; wb_reg_idx = 4'd7;
    applyStimulus("uf_retire");
    checkOutput("uf_set", 32'(underflow), 32'd1);
    idleInputs();
    repeat (2) applyStimulus("uf_hold");
    checkOutput("uf_sticky", 32'(underflow), 32'd1);

    // Downstream stall blocks issue without flagging a dependency
    fe_valid = 1; dest_write = 1; dest_idx = 4'd4; gpu_stall = 1;
    expectNow("gpu", 0, 0);
    applyStimulus("gpu");
    checkOutput("gpu_pending", 32'(pending), 32'd0);

    // Lock low freezes state even under writebacks
    idleInputs();
    fe_valid = 1; dest_write = 1; dest_idx = 4'd1;
    applyStimulus("lock_setup");
    lock = 0; dest_write = 0; src1_use = 1; src1_idx = 4'd1;
    wb_reg_wen = 1; wb_reg_idx = 4'd1;
    expectNow("lock_off", 0, 0);
    repeat (2) applyStimulus("lock_off");
    checkOutput("lock_pending", 32'(pending), 32'd1);
    lock = 1; fe_valid = 0; src1_use = 0;
    applyStimulus("lock_resume");

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      lock        = ($urandom_range(0, 9) != 0);
      fe_valid    = ($urandom_range(0, 3) != 0);
      gpu_stall   = ($urandom_range(0, 7) == 0);
      src1_idx    = 4'($urandom_range(0, 5));
      src2_idx    = 4'($urandom_range(0, 5));
      dest_idx    = 4'($urandom_range(0, 5));
      wb_reg_idx  = 4'($urandom_range(0, 5));
      vsrc1_idx   = 6'($urandom_range(0, 5));
      vsrc2_idx   = 6'($urandom_range(0, 5));
      vdest_idx   = 6'($urandom_range(0, 5));
      wb_vreg_idx = 6'($urandom_range(0, 5));
      src1_use    = 1'($urandom_range(0, 1));
      src2_use    = 1'($urandom_range(0, 1));
      vsrc1_use   = 1'($urandom_range(0, 1));
      vsrc2_use   = 1'($urandom_range(0, 1));
      cc_use      = ($urandom_range(0, 3) == 0);
      dest_write  = 1'($urandom_range(0, 1));
      vdest_write = 1'($urandom_range(0, 1));
      cc_write    = ($urandom_range(0, 3) == 0);
      wb_reg_wen  = ($urandom_range(0, 2) == 0);
      wb_vreg_wen = ($urandom_range(0, 2) == 0);
      wb_cc_wen   = ($urandom_range(0, 4) == 0);
      applyStimulus("rnd");
    end

    // Final reset clears everything, including the underflow flag
    idleInputs();
    reset = 1;
    applyStimulus("final_reset");
    checkOutput("final_pending", 32'(pending), 32'd0);
    checkOutput("final_underflow", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
